step_cmd_sequencer: RTL and testbench

//   Upstream command stage for the dual-step counter. Buffers step commands
//   (INC1 / INC2 / DEC1) from a valid/ready source in a small FIFO. Issues them
//   as single-cycle one-hot enables (en1 / en2 / en_d) with a programmable

---
 rtl/step_cmd_if.sv | 19 +
 rtl/step_cmd_sequencer.sv | 104 ++++++++++
 tb/tb_step_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_cmd_if.sv
// Command-side handshake and step-enable bundle between a command source and
// the step command sequencer.
interface step_cmd_if #(parameter int WIDTH = 4);
  logic             clr;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic             cmd_ready;
  logic             en1;
  logic             en2;
  logic             en_d;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             err;

  modport master (output clr, cmd_valid, cmd_op,
                  input  cmd_ready, en1, en2, en_d, count, busy, err);
  modport slave  (input  clr, cmd_valid, cmd_op,
                  output cmd_ready, en1, en2, en_d, count, busy, err);
endinterface

// File: rtl/step_cmd_sequencer.sv
// Buffers INC1/INC2/DEC1 commands in a small FIFO and issues them as one-hot
// step pulses with a hold-off gap, rejecting steps that would wrap the count.
module step_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic     clk,
  input  logic     rst,
  step_cmd_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [1:0] OP_INC1 = 2'b01;
  localparam logic [1:0] OP_INC2 = 2'b10;
  localparam logic [1:0] OP_DEC1 = 2'b11;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_n;
  logic [1:0]       fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;
  logic [2:0]       gap_cnt, gap_n;
  logic [WIDTH-1:0] count, count_n;
  logic             err, err_n;
  logic [2:0]       en, en_n;   // {en_d, en2, en1}
  logic             full, empty, push, pop;
  logic [1:0]       head;

  assign full  = (occ == (AW+1)'(DEPTH));
  assign empty = (occ == '0);
  assign push  = bus.cmd_valid && !full;
  assign head  = fifo_mem[rd_ptr];

  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    count_n = count;
    err_n   = err;
    en_n    = '0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // Range check against the shadow count; rejected steps only flag err.
          case (head)
            OP_INC1: if (count != CMAX) begin
                       en_n = 3'b001; count_n = count + 1'b1;
                     end else err_n = 1'b1;
            OP_INC2: if (count <= CMAX - WIDTH'(2)) begin
                       en_n = 3'b010; count_n = count + WIDTH'(2);
                     end else err_n = 1'b1;
            OP_DEC1: if (count != '0) begin
                       en_n = 3'b100; count_n = count - 1'b1;
                     end else err_n = 1'b1;
            default: ;
          endcase
          if (en_n != '0 && GAP > 0) begin
            state_n = HOLD;
            gap_n   = 3'(GAP);
          end
        end
      end
      HOLD: begin
        gap_n = gap_cnt - 3'd1;
        if (gap_cnt <= 3'd1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; gap_cnt <= '0; count <= '0; err <= 1'b0; en <= '0;
      wr_ptr <= '0; rd_ptr <= '0; occ <= '0;
    end else if (bus.clr) begin
      state <= IDLE; gap_cnt <= '0; count <= '0; err <= 1'b0; en <= '0;
      wr_ptr <= '0; rd_ptr <= '0; occ <= '0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
      count   <= count_n;
      err     <= err_n;
      en      <= en_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !bus.clr && !rst) fifo_mem[wr_ptr] <= bus.cmd_op;
  end

  assign bus.cmd_ready = !full;
  assign bus.en1       = en[0];
  assign bus.en2       = en[1];
  assign bus.en_d      = en[2];
  assign bus.count     = count;
  assign bus.err       = err;
  assign bus.busy      = !empty || (state == HOLD) || (en != '0);
endmodule

// File: tb/tb_step_cmd_sequencer.sv
// Randomized and directed bench for step_cmd_sequencer with a queue-based
// scoreboard fed by an arithmetic count model.
module tb_step_cmd_sequencer;
  localparam int W = 4;
  localparam int CMAXI = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  step_cmd_if #(.WIDTH(W)) b0();
  step_cmd_if #(.WIDTH(W)) b1();

  step_cmd_sequencer #(.WIDTH(W), .DEPTH(4), .GAP(1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  step_cmd_sequencer #(.WIDTH(W), .DEPTH(4), .GAP(0)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct { logic [1:0] op; int cnt; } exp_t;
  typedef struct { int cyc; logic [1:0] op; } ev_t;
  exp_t expq[$];
  ev_t  ev1[$];
  int   en_cyc[$];
  int   push_cyc[$];
  int   m_cnt = 0;
  bit   m_err = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    expq.delete(); m_cnt = 0; m_err = 1'b0;
  endfunction

  // Outcome of each command is fixed at acceptance: the FIFO keeps order and
  // only pops move the count, so applying commands in push order is exact.
  function automatic void model_push(input logic [1:0] op);
    int d;
    exp_t e;
    case (op)
      2'd1: d = 1;
      2'd2: d = 2;
      2'd3: d = -1;
      default: d = 0;
    endcase
    if (d == 0) return;
    if (m_cnt + d < 0 || m_cnt + d > CMAXI) m_err = 1'b1;
    else begin
      m_cnt += d;
      e.op = op; e.cnt = m_cnt;
      expq.push_back(e);
    end
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      if (b0.clr) model_reset();
      else if (b0.cmd_valid && b0.cmd_ready) begin
        model_push(b0.cmd_op);
        push_cyc.push_back(cyc);
      end
    end
    cyc++;
  end

  // Scoreboard monitor for the GAP=1 instance
  always @(negedge clk) begin
    if (!rst) begin
      if (b0.en1 || b0.en2 || b0.en_d) begin
        logic [1:0] op;
        exp_t e;
        chk("onehot0", int'(b0.en1) + int'(b0.en2) + int'(b0.en_d), 1);
        op = b0.en1 ? 2'd1 : (b0.en2 ? 2'd2 : 2'd3);
        en_cyc.push_back(cyc);
        if (expq.size() == 0) chk("unexpected_enable_op", int'(op), 0);
        else begin
          e = expq.pop_front();
          chk("enable_op", int'(op), int'(e.op));
          chk("count_at_enable", int'(b0.count), e.cnt);
        end
      end
      if (!b0.busy) begin
        chk("idle_count", int'(b0.count), m_cnt);
        chk("idle_err", int'(b0.err), int'(m_err));
        chk("idle_pending", expq.size(), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (b1.en1 || b1.en2 || b1.en_d)) begin
      ev_t v;
      chk("onehot1", int'(b1.en1) + int'(b1.en2) + int'(b1.en_d), 1);
      v.cyc = cyc;
      v.op  = b1.en1 ? 2'd1 : (b1.en2 ? 2'd2 : 2'd3);
      ev1.push_back(v);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    b0.clr = 1'b1; b0.cmd_valid = 1'b0; tick(); b0.clr = 1'b0;
  endtask

  // Present op and hold it until accepted; leaves cmd_valid high.
  task automatic send(input logic [1:0] op);
    int n = 0;
    b0.cmd_valid = 1'b1; b0.cmd_op = op;
    while (!b0.cmd_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("send_timeout", n, 0);
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    b0.cmd_valid = 1'b0;
    do begin @(negedge clk); n++; end while (b0.busy && n < 300);
    if (n >= 300) chk("idle_timeout", n, 0);
    tick();
  endtask

  initial begin
    b0.clr = 1'b0; b0.cmd_valid = 1'b0; b0.cmd_op = 2'd0;
    b1.clr = 1'b0; b1.cmd_valid = 1'b0; b1.cmd_op = 2'd0;

    // Reset: stimulus while rst is held must be ignored
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 b0.cmd_valid = i[0]; b0.cmd_op = 2'd1;
    end
    b0.cmd_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_en", int'({b0.en1, b0.en2, b0.en_d}), 0);
    chk("rst_count", int'(b0.count), 0);
    chk("rst_err", int'(b0.err), 0);
    chk("rst_busy", int'(b0.busy), 0);
    chk("rst_ready", int'(b0.cmd_ready), 1);
    tick(); tick();

    // INC1, INC2, DEC1 back to back: latency and gap
    do_clr(); en_cyc.delete(); push_cyc.delete();
    send(2'd1); send(2'd2); send(2'd3); wait_idle();
    chk("seq_n_enables", en_cyc.size(), 3);
    if (en_cyc.size() == 3 && push_cyc.size() >= 1) begin
      chk("latency", en_cyc[0] - push_cyc[0], 2);
      chk("gap_a", en_cyc[1] - en_cyc[0], 2);
      chk("gap_b", en_cyc[2] - en_cyc[1], 2);
    end
    chk("seq_count", int'(b0.count), 2);
    chk("seq_err", int'(b0.err), 0);

    // Streaming INC1: FIFO fills after 7 accepted pushes
    do_clr();
    begin
      int acc = 0, n = 0;
      b0.cmd_valid = 1'b1; b0.cmd_op = 2'd1;
      while (n < 50) begin
        @(negedge clk); n++;
        if (b0.cmd_ready) acc++; else break;
      end
      chk("first_full_after", acc, 7);
      while (acc < 10 && n < 100) begin
        @(negedge clk); n++;
        if (b0.cmd_ready) acc++;
      end
      @(posedge clk); #1;
      wait_idle();
      chk("stream_count", int'(b0.count), 10);
    end

    // Upper boundary
    do_clr();
    for (int i = 0; i < 14; i++) send(2'd1);
    send(2'd2); wait_idle();
    chk("inc2_reject_count", int'(b0.count), 14);
    chk("inc2_reject_err", int'(b0.err), 1);
    send(2'd1); wait_idle();
    chk("inc1_to_max", int'(b0.count), 15);
    send(2'd1); wait_idle();
    chk("inc1_reject_count", int'(b0.count), 15);
    chk("inc1_reject_err", int'(b0.err), 1);

    // Lower boundary
    do_clr();
    send(2'd3); wait_idle();
    chk("dec_reject_count", int'(b0.count), 0);
    chk("dec_reject_err", int'(b0.err), 1);

    // GAP=0 instance: consecutive pulses
    b1.clr = 1'b1; tick(); b1.clr = 1'b0; ev1.delete();
    b1.cmd_valid = 1'b1; b1.cmd_op = 2'd1; tick();
    b1.cmd_op = 2'd1; tick();
    b1.cmd_op = 2'd3; tick();
    b1.cmd_valid = 1'b0;
    repeat (6) tick();
    chk("gap0_n", ev1.size(), 3);
    if (ev1.size() == 3) begin
      chk("gap0_op0", int'(ev1[0].op), 1);
      chk("gap0_op1", int'(ev1[1].op), 1);
      chk("gap0_op2", int'(ev1[2].op), 3);
      chk("gap0_step1", ev1[1].cyc - ev1[0].cyc, 1);
      chk("gap0_step2", ev1[2].cyc - ev1[1].cyc, 1);
    end
    chk("gap0_count", int'(b1.count), 1);

    // clr while holding off with commands queued
    do_clr();
    begin
      int seen = 0, n = 0;
      b0.cmd_valid = 1'b1; b0.cmd_op = 2'd1;
      while (seen < 2 && n < 30) begin
        @(negedge clk); n++;
        if (b0.en1) seen++;
      end
      chk("clr_setup_pulses", seen, 2);
      #1 b0.clr = 1'b1; b0.cmd_valid = 1'b0;
      @(posedge clk); #1 b0.clr = 1'b0;
      @(negedge clk);
      chk("clr_busy", int'(b0.busy), 0);
      chk("clr_count", int'(b0.count), 0);
      chk("clr_err", int'(b0.err), 0);
      repeat (5) tick();
    end

    // Async reset drops a live en2 pulse
    do_clr();
    send(2'd2); b0.cmd_valid = 1'b0;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!b0.en2 && n < 10);
      chk("en2_seen", int'(b0.en2), 1);
      #1 rst = 1'b1; model_reset();
      #1 chk("rst_drops_en2", int'(b0.en2), 0);
      chk("rst_async_count", int'(b0.count), 0);
      @(posedge clk); #1 rst = 1'b0;
      tick();
    end

    // Randomized traffic with occasional flush
    do_clr();
    for (int i = 0; i < 600; i++) begin
      b0.cmd_op    = 2'($urandom_range(0, 3));
      b0.cmd_valid = ($urandom_range(0, 3) != 0);
      b0.clr       = ($urandom_range(0, 80) == 0);
      tick();
    end
    b0.clr = 1'b0;
    wait_idle();
    chk("final_count", int'(b0.count), m_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
